ram1_uart_ctrl: RTL and testbench
=================================

// Module: ram1_uart_ctrl
// PURPOSE
// - Memory-stage bus sequencer between the MEM stage and the shared RAM1/UART data bus.
// - Turns single MEM-stage load/store requests into timed SRAM strobes or UART wrn/rdn handshakes.
// - Holds the pipeline (rco_stall) until the access completes.
// - Returns load data to MEM, which forwards it to MEM/WB.
// PARAMETERS
// UART_DATA_ADDR  16'hBF00  UART data register address (R: rx byte, W: tx byte)
// UART_STAT_ADDR  16'hBF01  UART status address; read-only, {14'b0, rx_ready, tx_idle}
// TX_TIMEOUT      1023      max cycles in TX_WAIT before forced completion with error
// PORTS
// rci_clk          in     1   pipeline clock (same clock as cpu_clk)
// rci_rst          in     1   asynchronous, active-low reset
// rci_req          in     1   access request; held stable by MEM until rco_done
// rci_rwe          in     2   2'b01 read, 2'b10 write, others = no access
// rci_addr         in     16  word address
// rci_wdata        in     16  store data
// rco_rdata        out    16  load result; valid while rco_done=1, held until next read
// rco_done         out    1   one-cycle completion pulse
// rco_stall        out    1   freeze PC..EXE/MEM registers
// rco_err          out    1   pulses with rco_done on TX timeout
// rco_ram1_en      out    1   RAM1 chip enable, active-low
// rco_ram1_we      out    1   RAM1 write enable, active-low
// rco_ram1_oe      out    1   RAM1 output enable, active-low
// rco_ram1_addr    out    16  RAM1 address
// rcio_ram1_data   inout  16  shared RAM1/UART data bus
// rci_uart_tbre    in     1   UART tx buffer empty
// rci_uart_tsre    in     1   UART tx shift register empty
// rci_uart_data_ready in  1   UART rx byte available
// rco_uart_wrn     out    1   UART write strobe, active-low
// rco_uart_rdn     out    1   UART read strobe, active-low
// BEHAVIOUR
// - Reset (rci_rst=0, async): state IDLE; en/we/oe=1; addr=0; data bus Z; wrn/rdn=1.
//   Also rdata=0, done=0, err=0, timeout counter=0.
// - Reset mid-access: strobes deassert immediately; the access is abandoned.
// - Decode, sampled in IDLE: addr==UART_DATA_ADDR -> UART path; addr==UART_STAT_ADDR -> STAT; else RAM.
// - Any UART/STAT access: rco_ram1_en=1 (SRAM off the bus) for its whole duration.
// - rco_stall = (state!=IDLE & !rco_done) | (state==IDLE & rci_req & rwe in {01,10}).
// - rci_req with rwe 00/11: ignored; no stall, no done.
// - FSM states and transitions:
//   - IDLE -> RD_RAM / WR_RAM1 / RD_UART1 / WR_UART1 / STAT as decoded.
//   - RD_RAM: en=0, oe=0, addr driven, bus Z; latch bus at clock edge; -> DONE.
//   - WR_RAM1: en=0, oe=1, we=0, bus=wdata; -> WR_RAM2.
//   - WR_RAM2: we=1, bus and addr still driven (hold time); -> DONE.
//   - STAT: rdata={14'b0, data_ready, tbre&tsre}; -> DONE.
//   - RD_UART1: wait while data_ready=0 (no timeout); when 1, rdn=0, bus Z; -> RD_UART2.
//   - RD_UART2: rdn=0; latch rdata={8'h00, bus[7:0]}; -> DONE (rdn=1 in DONE).
//   - WR_UART1: bus=wdata, wrn=0; -> WR_UART2.
//   - WR_UART2: wrn=1, bus held; -> TX_WAIT.
//   - TX_WAIT: counter increments each cycle; tbre=1 & tsre=1 -> DONE.
//     counter==TX_TIMEOUT -> DONE with rco_err=1. Counter clears on leaving.
//   - DONE: rco_done=1 for exactly one cycle, all strobes inactive; -> IDLE.
// - Back-to-back requests: next request is accepted in the IDLE cycle right after DONE.
// - Latency from acceptance to done: RAM read 2, STAT 2, RAM write 3, UART write >=4.
//   UART read = 3 + wait for data_ready.
// - Bus tristate: driven only in WR_RAM1/2 and WR_UART1/2; Z in every other state.
// - rco_ram1_addr: registered from rci_addr at acceptance; held until next acceptance.
// - rdata: updates only on read completion; writes leave it unchanged.
// TESTING
// - RAM: write 0x1234 to 0x4000, then read 0x4000.
//   -> we low exactly 1 cycle; bus driven 2 cycles; rdata=0x1234; stall drops with done.
// - STAT: tbre=tsre=1, data_ready=0, read 0xBF01 -> rdata=0x0001, en=1 throughout.
//   Repeat with data_ready=1 -> 0x0003.
// - UART read: data_ready=0 for 5 cycles, then 1 with bus=0x5A.
//   -> rdn stays 1 while waiting; rdn low 2 cycles; rdata=0x005A; done 1 cycle.
// - UART write 0x0041, tsre rising 6 cycles after wrn rises -> wrn low 1 cycle; done after tsre; err=0.
// - Timeout: TX_TIMEOUT=8, tsre stuck 0 -> done and err pulse together 8 cycles into TX_WAIT.
// - Reset pulse during WR_RAM1 -> we, en, wrn go 1 and bus goes Z without a clock.
//   State IDLE; a new req after reset completes normally.

Source files
------------

// File: rtl/ram1_uart_ctrl.sv
// Memory-stage bus sequencer for the shared RAM1/UART data bus.
// Turns one MEM-stage load/store into SRAM strobes or a UART rdn/wrn
// handshake, stalls the pipeline while busy and returns load data.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a request, decodes address on acceptance
// RD_RAM   | SRAM read, en/oe low, bus latched at the closing edge
// WR_RAM1  | SRAM write, we low, bus driven with store data
// WR_RAM2  | we released, bus/addr held for hold time
// STAT     | UART status snapshot into rdata
// RD_UART1 | wait for rx byte, rdn drops once data_ready is seen
// RD_UART2 | rdn held low, rx byte latched at the closing edge
// WR_UART1 | bus driven, wrn low
// WR_UART2 | wrn released, bus held
// TX_WAIT  | wait for tx empty or timeout
// DONE     | one-cycle completion, all strobes inactive
module ram1_uart_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned TX_TIMEOUT     = 1023
) (
  input  logic        rci_clk,
  input  logic        rci_rst,
  input  logic        rci_req,
  input  logic [1:0]  rci_rwe,
  input  logic [15:0] rci_addr,
  input  logic [15:0] rci_wdata,
  output logic [15:0] rco_rdata,
  output logic        rco_done,
  output logic        rco_stall,
  output logic        rco_err,
  output logic        rco_ram1_en,
  output logic        rco_ram1_we,
  output logic        rco_ram1_oe,
  output logic [15:0] rco_ram1_addr,
  inout  wire  [15:0] rcio_ram1_data,
  input  logic        rci_uart_tbre,
  input  logic        rci_uart_tsre,
  input  logic        rci_uart_data_ready,
  output logic        rco_uart_wrn,
  output logic        rco_uart_rdn
);

  localparam int CW = $clog2(TX_TIMEOUT + 1);
  // TX_WAIT has lasted TX_TIMEOUT cycles once the counter shows TX_TIMEOUT-1
  localparam logic [CW-1:0] TO_LAST = CW'(TX_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, RD_RAM, WR_RAM1, WR_RAM2, STAT, RD_UART1, RD_UART2,
    WR_UART1, WR_UART2, TX_WAIT, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tx_cnt;
  logic [15:0]   rdata_q;
  logic [15:0]   addr_q;
  logic          err_q;
  logic          bus_drive;
  logic          access;
  logic          tx_empty;
  logic          tx_timeout;

  assign access     = rci_req & ((rci_rwe == 2'b01) | (rci_rwe == 2'b10));
  assign tx_empty   = rci_uart_tbre & rci_uart_tsre;
  assign tx_timeout = (state == TX_WAIT) & ~tx_empty & (tx_cnt == TO_LAST);

  assign rcio_ram1_data = bus_drive ? rci_wdata : 16'bz;
  assign rco_rdata      = rdata_q;
  assign rco_ram1_addr  = addr_q;
  assign rco_err        = err_q;
  assign rco_done       = (state == DONE);
  assign rco_stall      = ((state != IDLE) & (state != DONE)) | ((state == IDLE) & access);

  // State register
  always_ff @(posedge rci_clk or negedge rci_rst) begin
    if (!rci_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Address capture, read data latch, tx timeout counter and error flag
  always_ff @(posedge rci_clk or negedge rci_rst) begin
    if (!rci_rst) begin
      addr_q  <= 16'h0000;
      rdata_q <= 16'h0000;
      tx_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state == IDLE) && access) addr_q <= rci_addr;
      case (state)
        RD_RAM:   rdata_q <= rcio_ram1_data;
        STAT:     rdata_q <= {14'b0, rci_uart_data_ready, tx_empty};
        RD_UART2: rdata_q <= {8'h00, rcio_ram1_data[7:0]};
        default:  rdata_q <= rdata_q;
      endcase
      if ((state == TX_WAIT) && (state_nxt == TX_WAIT)) tx_cnt <= tx_cnt + CW'(1);
      else                                                tx_cnt <= '0;
      // Only ever high during the DONE cycle that follows a timeout
      err_q <= tx_timeout;
    end
  end

  // Next-state decode and bus strobes
  always_comb begin
    state_nxt    = state;
    rco_ram1_en  = 1'b1;
    rco_ram1_we  = 1'b1;
    rco_ram1_oe  = 1'b1;
    rco_uart_wrn = 1'b1;
    rco_uart_rdn = 1'b1;
    bus_drive    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (rci_addr == UART_DATA_ADDR)
            state_nxt = (rci_rwe == 2'b01) ? RD_UART1 : WR_UART1;
          else if (rci_addr == UART_STAT_ADDR)
            state_nxt = (rci_rwe == 2'b01) ? STAT : DONE;
          else
            state_nxt = (rci_rwe == 2'b01) ? RD_RAM : WR_RAM1;
        end
      end
      RD_RAM: begin
        rco_ram1_en = 1'b0;
        rco_ram1_oe = 1'b0;
        state_nxt   = DONE;
      end
      WR_RAM1: begin
        rco_ram1_en = 1'b0;
        rco_ram1_we = 1'b0;
        bus_drive   = 1'b1;
        state_nxt   = WR_RAM2;
      end
      WR_RAM2: begin
        rco_ram1_en = 1'b0;
        bus_drive   = 1'b1;
        state_nxt   = DONE;
      end
      STAT: state_nxt = DONE;
      RD_UART1: begin
        if (rci_uart_data_ready) begin
          rco_uart_rdn = 1'b0;
          state_nxt    = RD_UART2;
        end
      end
      RD_UART2: begin
        rco_uart_rdn = 1'b0;
        state_nxt    = DONE;
      end
      WR_UART1: begin
        rco_uart_wrn = 1'b0;
        bus_drive    = 1'b1;
        state_nxt    = WR_UART2;
      end
      WR_UART2: begin
        bus_drive = 1'b1;
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_empty || tx_timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram1_uart_ctrl.sv
// Directed bench for ram1_uart_ctrl with a small SRAM/UART model on the bus
// and a scoreboard of expected completions.
module tb_ram1_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  rwe = 2'b00;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        done, stall, err;
  logic        ram1_en, ram1_we, ram1_oe;
  logic [15:0] ram1_addr;
  wire  [15:0] ram1_data;
  logic        tbre = 1'b1, tsre = 1'b1, data_ready = 1'b0;
  logic        uart_wrn, uart_rdn;

  logic [15:0] sram [0:255];
  logic [15:0] uart_byte = 16'h7E5A;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [15:0] last_rd = 16'h0000;
  int lat, we_lo, drv_cnt, rdn_lo, wrn_lo, en_lo, stall_gap;

  ram1_uart_ctrl #(.TX_TIMEOUT(8)) dut (
    .rci_clk(clk), .rci_rst(rst), .rci_req(req), .rci_rwe(rwe),
    .rci_addr(addr), .rci_wdata(wdata), .rco_rdata(rdata), .rco_done(done),
    .rco_stall(stall), .rco_err(err), .rco_ram1_en(ram1_en), .rco_ram1_we(ram1_we),
    .rco_ram1_oe(ram1_oe), .rco_ram1_addr(ram1_addr), .rcio_ram1_data(ram1_data),
    .rci_uart_tbre(tbre), .rci_uart_tsre(tsre), .rci_uart_data_ready(data_ready),
    .rco_uart_wrn(uart_wrn), .rco_uart_rdn(uart_rdn)
  );

  always #5 clk = ~clk;

  // SRAM and UART answer on the bus when the DUT asks for read data
  assign ram1_data = (!uart_rdn) ? uart_byte :
                     (!ram1_en && !ram1_oe) ? sram[ram1_addr[7:0]] : 16'bz;

  // SRAM captures store data while we is low
  always @(negedge clk) begin
    if (rst && !ram1_en && !ram1_we) sram[ram1_addr[7:0]] <= ram1_data;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  // Issue one access from an IDLE negedge and follow it to DONE.
  // rdy_at: cycle after acceptance at which data_ready rises (-1 = never)
  // tsre_dly: cycles after wrn rises at which tsre rises (-1 = never)
  task automatic access(input string tag, input logic [1:0] rw, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd_exp,
                        input logic exp_err, input int exp_lat,
                        input int rdy_at, input int tsre_dly);
    exp_t e;
    int   tsre_at;
    logic wrn_prev;
    bit   seen;
    if (rw == 2'b01) last_rd = rd_exp;
    e.tag = tag; e.rdata = last_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    req = 1'b1; rwe = rw; addr = a; wdata = wd;
    #1;
    check({tag, "_stall_accept"}, stall, 1'b1);
    lat = 0; we_lo = 0; drv_cnt = 0; rdn_lo = 0; wrn_lo = 0; en_lo = 0; stall_gap = 0;
    tsre_at = -1; wrn_prev = 1'b1; seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == rdy_at) data_ready = 1'b1;
      if (lat == tsre_at) tsre = 1'b1;
      @(negedge clk);
      if (!ram1_we) we_lo++;
      if (rw == 2'b10 && ram1_data === wd) drv_cnt++;
      if (!uart_rdn) rdn_lo++;
      if (!uart_wrn) wrn_lo++;
      if (!ram1_en) en_lo++;
      if (!wrn_prev && uart_wrn && tsre_dly >= 0) tsre_at = lat + tsre_dly;
      wrn_prev = uart_wrn;
      if (done) begin
        seen = 1;
        e = sb.pop_front();
        check({e.tag, "_rdata"}, rdata, e.rdata);
        check({e.tag, "_err"}, err, e.err);
        check({e.tag, "_latency"}, lat, e.lat);
        check({e.tag, "_stall_at_done"}, stall, 1'b0);
      end else if (!stall) begin
        stall_gap++;
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    if (!seen && sb.size() > 0) void'(sb.pop_front());
    check({tag, "_stall_gap"}, stall_gap, 0);
    req = 1'b0; rwe = 2'b00;
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_err_one_cycle"}, err, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
    #1 rst = 1'b0;
    #2;
    check("rst_en", ram1_en, 1'b1);
    check("rst_we", ram1_we, 1'b1);
    check("rst_oe", ram1_oe, 1'b1);
    check("rst_wrn", uart_wrn, 1'b1);
    check("rst_rdn", uart_rdn, 1'b1);
    check("rst_addr", ram1_addr, 16'h0000);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    access("ram_wr", 2'b10, 16'h4000, 16'h1234, 16'h0000, 1'b0, 3, -1, -1);
    check("ram_wr_we_cycles", we_lo, 1);
    check("ram_wr_bus_cycles", drv_cnt, 2);
    check("ram_wr_en_cycles", en_lo, 2);
    check("ram_wr_addr", ram1_addr, 16'h4000);

    access("ram_rd", 2'b01, 16'h4000, 16'h0000, 16'h1234, 1'b0, 2, -1, -1);
    check("ram_rd_en_cycles", en_lo, 1);

    access("ram_wr2", 2'b10, 16'h4001, 16'hBEEF, 16'h0000, 1'b0, 3, -1, -1);
    access("ram_rd2", 2'b01, 16'h4001, 16'h0000, 16'hBEEF, 1'b0, 2, -1, -1);

    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;
    access("stat0", 2'b01, 16'hBF01, 16'h0000, 16'h0001, 1'b0, 2, -1, -1);
    check("stat0_en_cycles", en_lo, 0);
    data_ready = 1'b1;
    access("stat1", 2'b01, 16'hBF01, 16'h0000, 16'h0003, 1'b0, 2, -1, -1);
    check("stat1_en_cycles", en_lo, 0);

    data_ready = 1'b0;
    access("uart_rd", 2'b01, 16'hBF00, 16'h0000, 16'h005A, 1'b0, 7, 5, -1);
    check("uart_rd_rdn_cycles", rdn_lo, 2);
    check("uart_rd_en_cycles", en_lo, 0);
    data_ready = 1'b0;

    tbre = 1'b1; tsre = 1'b0;
    access("uart_wr", 2'b10, 16'hBF00, 16'h0041, 16'h0000, 1'b0, 9, -1, 6);
    check("uart_wr_wrn_cycles", wrn_lo, 1);
    check("uart_wr_bus_cycles", drv_cnt, 2);
    check("uart_wr_en_cycles", en_lo, 0);

    tsre = 1'b0;
    access("tx_timeout", 2'b10, 16'hBF00, 16'h0055, 16'h0000, 1'b1, 11, -1, -1);
    check("tx_timeout_wrn_cycles", wrn_lo, 1);
    tsre = 1'b1;

    for (int k = 0; k < 2; k++) begin
      req = 1'b1; rwe = (k == 0) ? 2'b00 : 2'b11; addr = 16'h4000;
      #1;
      check("ignore_stall_now", stall, 1'b0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("ignore_stall", stall, 1'b0);
        check("ignore_done", done, 1'b0);
        check("ignore_en", ram1_en, 1'b1);
      end
    end
    req = 1'b0; rwe = 2'b00;
    @(negedge clk);

    req = 1'b1; rwe = 2'b10; addr = 16'h4002; wdata = 16'hCAFE;
    @(posedge clk);
    #1;
    check("midrst_we_active", ram1_we, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_we", ram1_we, 1'b1);
    check("midrst_en", ram1_en, 1'b1);
    check("midrst_wrn", uart_wrn, 1'b1);
    check("midrst_bus_released", ram1_data === 16'hCAFE, 1'b0);
    check("midrst_rdata", rdata, 16'h0000);
    check("midrst_addr", ram1_addr, 16'h0000);
    req = 1'b0; rwe = 2'b00;
    last_rd = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall_idle", stall, 1'b0);
    access("post_rst_rd", 2'b01, 16'h4000, 16'h0000, 16'h1234, 1'b0, 2, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
